// File: rtl/udp_tx_packetizer_pkg.sv
// Shared types and constants for the UDP transmit packetizer.
package udp_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PORT_W = 16;

  localparam logic [PORT_W-1:0] DEFAULT_PORT = 16'h1000;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } state_t;

  typedef struct packed {
    logic [PORT_W-1:0] dest_port;
    logic [PORT_W-1:0] src_port;
    logic [PORT_W-1:0] length;
  } udp_hdr_t;

endpackage

// File: rtl/udp_tx_packetizer_if.sv
// Header-field handshake plus AXI-Stream byte channel towards the UDP/IP stack.
interface udp_tx_if;
  import udp_pkg::*;

  logic              hdr_valid;
  logic              hdr_ready;
  logic [PORT_W-1:0] hdr_dest_port;
  logic [PORT_W-1:0] hdr_src_port;
  logic [PORT_W-1:0] hdr_length;
  logic [BYTE_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport master (
    output hdr_valid, hdr_dest_port, hdr_src_port, hdr_length,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  hdr_ready, m_axis_tready
  );

  modport slave (
    input  hdr_valid, hdr_dest_port, hdr_src_port, hdr_length,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output hdr_ready, m_axis_tready
  );

endinterface

// File: rtl/udp_tx_packetizer_fifo.sv
// First-word-fall-through word FIFO with occupancy count and registered flags.
module sync_word_fifo #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_n;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok  = wr_en & ~full;
  assign rd_ok  = rd_en & ~empty;
  assign dout_c = mem[rd_ptr];

  always_comb begin
    count_n = count + CW'(wr_ok) - CW'(rd_ok);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  // Flags are registered from the next count so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/udp_tx_packetizer.sv
// Buffers 32-bit samples and emits them as UDP payloads: header handshake,
// then an MSB-first byte stream with tlast on the final byte.
module udp_tx_packetizer
  import udp_pkg::*;
#(
  parameter int unsigned       WORDS_PER_PKT = 256,
  parameter int unsigned       FIFO_DEPTH    = 1024,
  parameter logic [PORT_W-1:0] DEST_PORT     = DEFAULT_PORT,
  parameter logic [PORT_W-1:0] SRC_PORT      = DEFAULT_PORT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] din,
  output logic              full,
  output logic              empty,
  input  logic              flush,
  output logic              busy,
  output logic              overflow,
  udp_tx_if.master          tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  if ((FIFO_DEPTH * 4 > 65535) || (WORDS_PER_PKT == 0) || (WORDS_PER_PKT > FIFO_DEPTH) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_check
    $error("udp_tx_packetizer: illegal WORDS_PER_PKT/FIFO_DEPTH combination");
  end

  state_t            state, state_n;
  logic              hdr_valid, hdr_valid_n;
  logic [PORT_W-1:0] hdr_len, hdr_len_n;
  logic              tvalid, tvalid_n;
  logic              tlast, tlast_n;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [CW-1:0]     pkt_words, pkt_words_n;
  logic [CW-1:0]     word_cnt, word_cnt_n;
  logic              flush_lat, flush_lat_n;
  logic              busy_n;
  logic              pop_c;
  logic [WORD_W-1:0] fifo_dout_c;
  logic [CW-1:0]     fifo_count;
  udp_hdr_t          hdr_c;

  sync_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .din    (din),
    .rd_en  (pop_c),
    .dout_c (fifo_dout_c),
    .count  (fifo_count),
    .full   (full),
    .empty  (empty)
  );

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_n     = state;
    hdr_valid_n = hdr_valid;
    hdr_len_n   = hdr_len;
    tvalid_n    = tvalid;
    tlast_n     = tlast;
    shreg_n     = shreg;
    byte_idx_n  = byte_idx;
    pkt_words_n = pkt_words;
    word_cnt_n  = word_cnt;
    flush_lat_n = flush_lat | flush;
    pop_c       = 1'b0;

    unique case (state)
      IDLE: begin
        if (fifo_count >= CW'(WORDS_PER_PKT) || (flush_lat && fifo_count != '0)) begin
          pkt_words_n = (fifo_count >= CW'(WORDS_PER_PKT)) ? CW'(WORDS_PER_PKT) : fifo_count;
          hdr_len_n   = PORT_W'({pkt_words_n, 2'b00});
          hdr_valid_n = 1'b1;
          flush_lat_n = flush;
          state_n     = HDR;
        end else if (flush_lat) begin
          flush_lat_n = flush;
        end
      end

      HDR: begin
        if (tx.hdr_ready) begin
          hdr_valid_n = 1'b0;
          pop_c       = 1'b1;
          shreg_n     = fifo_dout_c;
          byte_idx_n  = 2'd0;
          word_cnt_n  = CW'(1);
          tvalid_n    = 1'b1;
          tlast_n     = 1'b0;
          state_n     = PAYLOAD;
        end
      end

      PAYLOAD: begin
        if (tx.m_axis_tready) begin
          if (byte_idx != 2'd3) begin
            byte_idx_n = byte_idx + 2'd1;
            shreg_n    = {shreg[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
            tlast_n    = (byte_idx == 2'd2) && (word_cnt == pkt_words);
          end else if (word_cnt == pkt_words) begin
            tvalid_n = 1'b0;
            tlast_n  = 1'b0;
            shreg_n  = '0;
            state_n  = IDLE;
          end else begin
            // Next word loads on the same edge as the last byte: no bubble.
            pop_c      = 1'b1;
            shreg_n    = fifo_dout_c;
            byte_idx_n = 2'd0;
            word_cnt_n = word_cnt + CW'(1);
            tlast_n    = 1'b0;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hdr_valid <= 1'b0;
      hdr_len   <= '0;
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      shreg     <= '0;
      byte_idx  <= 2'd0;
      pkt_words <= '0;
      word_cnt  <= '0;
      flush_lat <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      hdr_valid <= hdr_valid_n;
      hdr_len   <= hdr_len_n;
      tvalid    <= tvalid_n;
      tlast     <= tlast_n;
      shreg     <= shreg_n;
      byte_idx  <= byte_idx_n;
      pkt_words <= pkt_words_n;
      word_cnt  <= word_cnt_n;
      flush_lat <= flush_lat_n;
      busy      <= busy_n;
      overflow  <= overflow | (wr_en & full);
    end
  end

  assign hdr_c = '{dest_port: DEST_PORT, src_port: SRC_PORT, length: hdr_len};

  assign tx.hdr_valid     = hdr_valid;
  assign tx.hdr_dest_port = hdr_c.dest_port;
  assign tx.hdr_src_port  = hdr_c.src_port;
  assign tx.hdr_length    = hdr_c.length;
  assign tx.m_axis_tdata  = shreg[WORD_W-1 -: BYTE_W];
  assign tx.m_axis_tvalid = tvalid;
  assign tx.m_axis_tlast  = tlast;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Directed bench: packets expected from written words are queued as bytes and
// header lengths, and a negedge monitor compares every handshake against them.
module tb_udp_tx_packetizer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] din;
  logic        flush;
  logic        full;
  logic        empty;
  logic        busy;
  logic        overflow;

  udp_tx_if tx ();

  udp_tx_packetizer #(
    .WORDS_PER_PKT (4),
    .FIFO_DEPTH    (8),
    .DEST_PORT     (16'h1000),
    .SRC_PORT      (16'h1000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .din      (din),
    .full     (full),
    .empty    (empty),
    .flush    (flush),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] len_q  [$];
  logic [7:0]  byte_q [$];
  logic        last_q [$];

  int tr_mode = 0;   // 0: tready high, 1: toggle each cycle, 2: tready low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one payload: n words, MSB byte first, tlast on final byte.
  task automatic expect_pkt(input int n, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    logic [31:0] word;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    len_q.push_back(16'(n * 4));
    for (int i = 0; i < n; i++) begin
      word = w[i];
      for (int b = 0; b < 4; b++) begin
        byte_q.push_back(word[31 - 8*b -: 8]);
        last_q.push_back((i == n - 1) && (b == 3));
      end
    end
  endtask

  task automatic write_word(input logic [31:0] w);
    wr_en = 1'b1;
    din   = w;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // sel 0: hdr_valid, sel 1: m_axis_tvalid
  task automatic wait_for(input int sel, input string name);
    int n;
    logic c;
    n = 0;
    c = (sel == 0) ? tx.hdr_valid : tx.m_axis_tvalid;
    while (!c && n < 100) begin
      tick();
      n++;
      c = (sel == 0) ? tx.hdr_valid : tx.m_axis_tvalid;
    end
    check(name, 32'(c), 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    logic done;
    n = 0;
    done = (len_q.size() == 0) && (byte_q.size() == 0) && !busy;
    while (!done && n < 300) begin
      tick();
      n++;
      done = (len_q.size() == 0) && (byte_q.size() == 0) && !busy;
    end
    check(name, 32'(done), 32'd1);
    repeat (3) tick();
  endtask

  // tready pattern generator
  initial begin
    tx.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tr_mode)
        0:       tx.m_axis_tready = 1'b1;
        1:       tx.m_axis_tready = ~tx.m_axis_tready;
        default: tx.m_axis_tready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard on handshakes, stability under stall, tvalid run length.
  logic        tv_stall, hv_stall, st_last;
  logic [7:0]  st_data;
  logic [15:0] st_len;
  int          run, last_run;

  always @(negedge clk) begin
    if (rst) begin
      tv_stall = 1'b0;
      hv_stall = 1'b0;
      run      = 0;
    end else begin
      if (tv_stall) begin
        check("tvalid_hold", 32'(tx.m_axis_tvalid), 32'd1);
        check("tdata_hold", 32'(tx.m_axis_tdata), 32'(st_data));
        check("tlast_hold", 32'(tx.m_axis_tlast), 32'(st_last));
      end
      if (hv_stall) begin
        check("hdr_valid_hold", 32'(tx.hdr_valid), 32'd1);
        check("hdr_length_hold", 32'(tx.hdr_length), 32'(st_len));
      end
      if (tx.hdr_valid && tx.hdr_ready) begin
        check("hdr_expected", 32'(len_q.size() != 0), 32'd1);
        if (len_q.size() != 0) check("hdr_length", 32'(tx.hdr_length), 32'(len_q.pop_front()));
        check("hdr_dest_port", 32'(tx.hdr_dest_port), 32'h1000);
        check("hdr_src_port", 32'(tx.hdr_src_port), 32'h1000);
      end
      if (tx.m_axis_tvalid && tx.m_axis_tready) begin
        check("byte_expected", 32'(byte_q.size() != 0), 32'd1);
        if (byte_q.size() != 0) begin
          check("tdata", 32'(tx.m_axis_tdata), 32'(byte_q.pop_front()));
          check("tlast", 32'(tx.m_axis_tlast), 32'(last_q.pop_front()));
        end
      end
      if (tx.m_axis_tvalid) run++;
      else if (run != 0) begin
        last_run = run;
        run      = 0;
      end
      tv_stall = tx.m_axis_tvalid && !tx.m_axis_tready;
      st_data  = tx.m_axis_tdata;
      st_last  = tx.m_axis_tlast;
      hv_stall = tx.hdr_valid && !tx.hdr_ready;
      st_len   = tx.hdr_length;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hdr_seen;
    rst          = 1'b1;
    wr_en        = 1'b0;
    din          = '0;
    flush        = 1'b0;
    tx.hdr_ready = 1'b1;
    last_run     = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_hdr_valid", 32'(tx.hdr_valid), 32'd0);
    check("rst_tvalid", 32'(tx.m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(tx.m_axis_tlast), 32'd0);
    check("rst_tdata", 32'(tx.m_axis_tdata), 32'd0);
    check("rst_hdr_length", 32'(tx.hdr_length), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // Full packet, no backpressure, plus header latency
    tr_mode = 0;
    expect_pkt(4, 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F);
    check("model_len", 32'(len_q[0]), 32'd16);
    check("model_byte15", 32'(byte_q[15]), 32'h0F);
    check("model_last15", 32'(last_q[15]), 32'd1);
    check("model_last14", 32'(last_q[14]), 32'd0);
    write_word(32'h00010203);
    write_word(32'h04050607);
    write_word(32'h08090A0B);
    write_word(32'h0C0D0E0F);
    @(negedge clk);
    check("lat_hdr_pre", 32'(tx.hdr_valid), 32'd0);
    @(negedge clk);
    check("lat_hdr_valid", 32'(tx.hdr_valid), 32'd1);
    check("full_hdr_length", 32'(tx.hdr_length), 32'd16);
    tick();
    drain("drain_full");
    check("tvalid_run", 32'(last_run), 32'd16);

    // Backpressure on both header and byte stream
    tr_mode      = 1;
    tx.hdr_ready = 1'b0;
    expect_pkt(4, 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F);
    write_word(32'h00010203);
    write_word(32'h04050607);
    write_word(32'h08090A0B);
    write_word(32'h0C0D0E0F);
    wait_for(0, "bp_hdr_valid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hdr_wait", 32'(tx.hdr_valid), 32'd1);
      tick();
    end
    tx.hdr_ready = 1'b1;
    drain("drain_backpressure");

    // Partial flush, then flush with nothing buffered
    tr_mode = 0;
    expect_pkt(2, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'h0, 32'h0);
    write_word(32'hA1A2A3A4);
    write_word(32'hB1B2B3B4);
    repeat (3) tick();
    check("partial_no_launch", 32'(busy), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain("drain_partial");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    hdr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx.hdr_valid || busy) hdr_seen++;
      tick();
    end
    check("empty_flush_no_hdr", 32'(hdr_seen), 32'd0);

    // Overflow: header held off so nothing drains, ninth write dropped
    tr_mode      = 2;
    tx.hdr_ready = 1'b0;
    expect_pkt(4, 32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003);
    expect_pkt(4, 32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007);
    for (int i = 0; i < 8; i++) write_word(32'h10000000 + 32'(i));
    @(negedge clk);
    check("ovf_full_before", 32'(full), 32'd1);
    check("ovf_clear_before", 32'(overflow), 32'd0);
    tick();
    write_word(32'hDEADBEEF);
    @(negedge clk);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    tick();
    tr_mode      = 0;
    tx.hdr_ready = 1'b1;
    drain("drain_overflow");
    check("ovf_empty_after", 32'(empty), 32'd1);
    check("ovf_still_set", 32'(overflow), 32'd1);

    // Writes during PAYLOAD go to the next packet
    expect_pkt(4, 32'h20212223, 32'h24252627, 32'h28292A2B, 32'h2C2D2E2F);
    expect_pkt(4, 32'h30313233, 32'h34353637, 32'h38393A3B, 32'h3C3D3E3F);
    write_word(32'h20212223);
    write_word(32'h24252627);
    write_word(32'h28292A2B);
    write_word(32'h2C2D2E2F);
    wait_for(1, "conc_tvalid");
    write_word(32'h30313233);
    write_word(32'h34353637);
    write_word(32'h38393A3B);
    write_word(32'h3C3D3E3F);
    drain("drain_concurrent");

    // Asynchronous reset in the middle of a payload
    expect_pkt(4, 32'h40414243, 32'h44454647, 32'h48494A4B, 32'h4C4D4E4F);
    write_word(32'h40414243);
    write_word(32'h44454647);
    write_word(32'h48494A4B);
    write_word(32'h4C4D4E4F);
    wait_for(1, "mid_tvalid");
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 32'(tx.m_axis_tvalid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    len_q.delete();
    byte_q.delete();
    last_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_empty", 32'(empty), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_overflow", 32'(overflow), 32'd0);
    check("post_rst_hdr_valid", 32'(tx.hdr_valid), 32'd0);
    tick();

    // Recovery packet after reset
    expect_pkt(4, 32'h50515253, 32'h54555657, 32'h58595A5B, 32'h5C5D5E5F);
    write_word(32'h50515253);
    write_word(32'h54555657);
    write_word(32'h58595A5B);
    write_word(32'h5C5D5E5F);
    drain("drain_recovery");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_packetizer.md
Name: udp_tx_packetizer

Overview:
- Transmit-side counterpart of the UDP payload receive path.
- Accepts 32-bit sample words from capture logic and buffers them in a word FIFO.
- Emits complete UDP payloads as an 8-bit AXI-Stream byte stream, preceded by a header-field handshake, towards the UDP/IP transmit stack.
- A packet is emitted when WORDS_PER_PKT words are buffered, or earlier as a partial packet when a flush is requested.

Parameters:
- WORDS_PER_PKT, 256, 32-bit words per full packet (1..FIFO_DEPTH).
- FIFO_DEPTH, 1024, word FIFO depth; power of two, at least WORDS_PER_PKT.
- DEST_PORT, 16'h1000, UDP destination port placed in the header.
- SRC_PORT, 16'h1000, UDP source port placed in the header.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous reset, active-high.
- wr_en  in  1  write strobe for din; ignored while full=1.
- din  in  32  sample word; byte [31:24] is transmitted first.
- full  out  1  word FIFO full.
- empty  out  1  word FIFO empty.
- flush  in  1  single-cycle request to send buffered words as a partial packet.
- hdr_valid  out  1  header fields valid.
- hdr_ready  in  1  stack accepts the header.
- hdr_dest_port  out  16  equals DEST_PORT.
- hdr_src_port  out  16  equals SRC_PORT.
- hdr_length  out  16  payload length in bytes (4 × word count).
- m_axis_tdata  out  8  payload byte.
- m_axis_tvalid  out  1  byte valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last byte of the payload.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky; set when wr_en is asserted while full=1.

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied; full=0, empty=1.
  - hdr_valid=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, hdr_length=0.
  - busy=0, overflow=0, flush latch cleared, state=IDLE.
- Write side:
  - A word is stored when wr_en=1 and full=0.
  - A write with full=1 is dropped and sets overflow.
  - A write and a pop in the same cycle are both honoured; count is unchanged.
- Flush latch:
  - Set by flush=1 in any state.
  - Cleared when a packet is launched from IDLE.
- IDLE:
  - If count ≥ WORDS_PER_PKT, set pkt_words=WORDS_PER_PKT and go to HDR.
  - Else if the flush latch is set and count>0, set pkt_words=count and go to HDR.
  - Else if the flush latch is set and count=0, clear the latch and stay in IDLE; no packet is sent.
  - pkt_words is sampled at this transition; later writes do not extend the packet.
- HDR:
  - hdr_valid=1, hdr_length=pkt_words×4, held stable until hdr_valid & hdr_ready.
  - On the handshake, the first word is popped and the state goes to PAYLOAD the next cycle.
  - hdr_valid must not depend combinationally on hdr_ready.
- PAYLOAD:
  - Shift register holds the current word; byte index runs 0..3 (MSB first).
  - Word counter counts up to pkt_words.
  - m_axis_tvalid=1 continuously; tdata/tlast held stable while tready=0.
  - On tvalid & tready, advance the byte index.
  - After byte 3, load the next FIFO word with no bubble; throughput is 1 byte/clk while tready=1.
  - tlast=1 only on byte 3 of word pkt_words.
  - When that byte is accepted, deassert tvalid the next cycle and return to IDLE.
- Latency: from count reaching WORDS_PER_PKT in IDLE to hdr_valid=1 is 1 cycle.
- Guaranteed behaviour: the FIFO never underflows during PAYLOAD, because pkt_words ≤ count at launch.
- Widths:
  - hdr_length is 16 bits; FIFO_DEPTH×4 must be ≤ 65535 (elaboration-time assertion).
  - Counters are clog2(FIFO_DEPTH)+1 bits wide.
- Reset mid-packet: outputs drop immediately and all buffered data is discarded; downstream discards the truncated frame.

Decomposition:
- Shared package udp_pkg holds:
  - state enum {IDLE, HDR, PAYLOAD};
  - the default port constant 16'h1000;
  - typedef udp_hdr_t {dest_port, src_port, length}.
- One sub-module: sync_word_fifo (32-bit wide, FIFO_DEPTH deep, first-word-fall-through, count output, async reset).
- The packetizer FSM and byte serializer stay in the top module.

Test Plan:
- Full packet: WORDS_PER_PKT=4, write 0x00010203..0x0C0D0E0F, tready=1, hdr_ready=1.
  - Expect hdr_length=16 and bytes 0x00..0x0F in order.
  - tlast on 0x0F only; 16 consecutive tvalid cycles.
- Backpressure: same data, tready toggling 1/0 every cycle.
  - Expect tdata/tlast held while stalled and an identical byte sequence.
  - hdr_valid held 3 cycles when hdr_ready is delayed 3 cycles.
- Partial flush: write 2 words, pulse flush.
  - Expect hdr_length=8 and 8 bytes with tlast on byte 8.
  - A flush with an empty FIFO produces no hdr_valid.
- Overflow: FIFO_DEPTH=8, fill 8 words with tready=0, write a ninth.
  - Expect full=1 and overflow=1, and the ninth word absent from the output.
- Concurrent write: write during PAYLOAD of a full packet.
  - Current packet stays at WORDS_PER_PKT words.
  - The new words begin the next packet.
- Async reset mid-PAYLOAD: assert rst between clock edges.
  - Expect tvalid=0 immediately, then empty=1, busy=0, and state IDLE after release.
